// File: rtl/wshb2avlst.sv
// Wishbone pipelined slave that buffers 32-bit writes in a FIFO and streams them
// out as Avalon-ST with sop/eop framing every FRAME_WORDS words.
module wshb2avlst #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wshb_cyc,
    input  logic        wshb_stb,
    input  logic        wshb_we,
    input  logic [31:0] wshb_adr,
    input  logic [31:0] wshb_dat_ms,
    input  logic [3:0]  wshb_sel,
    output logic [31:0] wshb_dat_sm,
    output logic        wshb_ack,
    output logic        wshb_err,
    output logic        wshb_stall,
    output logic [31:0] avlst_data,
    output logic        avlst_valid,
    input  logic        avlst_ready,
    output logic        avlst_sop,
    output logic        avlst_eop
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_word_idx;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_dat_sm;

    logic w_accept;
    logic w_ctrl;
    logic w_full_sel;
    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_ok;
    logic w_rd_status;
    logic w_last_word;
    logic w_unused_bits;

    assign w_unused_bits = ^{wshb_adr[31:3], wshb_adr[1:0], wshb_dat_ms[31:1]};

    assign wshb_stall  = (r_count == CW'(FIFO_DEPTH));
    assign w_accept    = wshb_cyc & wshb_stb & ~wshb_stall;
    assign w_ctrl      = wshb_adr[2];
    assign w_full_sel  = (wshb_sel == 4'hF);
    assign w_push      = w_accept & wshb_we & ~w_ctrl & w_full_sel;
    assign w_flush     = w_accept & wshb_we & w_ctrl & wshb_dat_ms[0];
    assign w_rd_status = w_accept & ~wshb_we & w_ctrl;
    // CTRL/STATUS accepts everything; DATA only accepts full-word writes.
    assign w_ok        = w_ctrl | (wshb_we & w_full_sel);
    assign w_pop       = avlst_valid & avlst_ready;
    assign w_last_word = (r_word_idx == 16'(FRAME_WORDS - 1));

    assign avlst_valid = (r_count != '0);
    assign avlst_data  = r_mem[r_rptr];
    assign avlst_sop   = (r_word_idx == 16'd0);
    assign avlst_eop   = w_last_word;
    assign wshb_ack    = r_ack;
    assign wshb_err    = r_err;
    assign wshb_dat_sm = r_dat_sm;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wshb_dat_ms;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
        end else if (w_flush) begin
            // A pop in the flush cycle still completes on the sink side; state is then wiped.
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr     <= r_rptr + 1'b1;
                r_word_idx <= w_last_word ? 16'd0 : r_word_idx + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat_sm <= '0;
        end else begin
            r_ack    <= w_accept & w_ok;
            r_err    <= w_accept & ~w_ok;
            r_dat_sm <= w_rd_status ? {r_word_idx, 16'(r_count)} : 32'd0;
        end
    end
endmodule

// File: tb/tb_wshb2avlst.sv
// Directed bench for wshb2avlst with FIFO_DEPTH=4, FRAME_WORDS=3; the stream is
// scored against an expected queue of {sop, eop, data} entries.
module tb_wshb2avlst;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_ms = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_sm;
    logic        ack, err, stall;
    logic [31:0] st_data;
    logic        st_valid, st_sop, st_eop;
    logic        st_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [33:0] exp_q[$];
    logic        rand_ready_en = 1'b0;

    wshb2avlst #(.FIFO_DEPTH(4), .FRAME_WORDS(3)) dut (
        .sys_clk(clk), .sys_rst(rst_n),
        .wshb_cyc(cyc), .wshb_stb(stb), .wshb_we(we), .wshb_adr(adr),
        .wshb_dat_ms(dat_ms), .wshb_sel(sel), .wshb_dat_sm(dat_sm),
        .wshb_ack(ack), .wshb_err(err), .wshb_stall(stall),
        .avlst_data(st_data), .avlst_valid(st_valid), .avlst_ready(st_ready),
        .avlst_sop(st_sop), .avlst_eop(st_eop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream scoreboard: transfers pop the expected queue, stalled heads must match it.
    always @(negedge clk) begin
        if (rst_n && st_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {st_sop, st_eop, st_data}, 34'h3_DEAD_BEEF);
            end else if (st_ready) begin
                check("stream", {st_sop, st_eop, st_data}, exp_q.pop_front());
            end else begin
                check("hold", {st_sop, st_eop, st_data}, exp_q[0]);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1 st_ready = 1'($urandom_range(0, 1));
        end
    end

    // Single request; called and returns just after a rising edge.
    task automatic wb_single(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic o_ack, output logic o_err,
                             output logic [31:0] o_dat);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!stall) break;
            @(posedge clk); #1;
        end
        if (n == 50) check("stall_timeout", 34'd1, 34'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        o_ack = ack; o_err = err; o_dat = dat_sm;
        @(posedge clk); #1;
    endtask

    task automatic push_word(input string tag, input logic [31:0] d, input logic s, input logic e);
        logic a, r; logic [31:0] q;
        exp_q.push_back({s, e, d});
        wb_single(1'b1, 32'h0, d, 4'hF, a, r, q);
        check(tag, {a, r}, 34'b10);
    endtask

    task automatic drain(input string tag);
        int n;
        st_ready = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!st_valid) break;
        end
        if (n == 100) check({tag, "_timeout"}, 34'd1, 34'd0);
        check({tag, "_left"}, 34'(exp_q.size()), 34'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic a, r;
        logic [31:0] q;
        logic [31:0] t1_data [4];
        t1_data[0] = 32'h11; t1_data[1] = 32'h22; t1_data[2] = 32'h33; t1_data[3] = 32'h44;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {ack, err, stall, st_valid, st_sop, st_eop}, 34'b000010);
        check("rst_dat_sm", dat_sm, 34'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back pipelined pushes with the sink always ready.
        st_ready = 1'b1;
        exp_q.push_back({2'b10, 32'h11});
        exp_q.push_back({2'b00, 32'h22});
        exp_q.push_back({2'b01, 32'h33});
        exp_q.push_back({2'b10, 32'h44});
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            dat_ms = t1_data[i];
            @(negedge clk);
            check("t1_stall", stall, 34'd0);
            check("t1_ack", ack, (i > 0) ? 34'd1 : 34'd0);
            if (i == 1) check("t1_latency", st_valid, 34'd1);
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("t1_ack_last", ack, 34'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_ack_pulse", ack, 34'd0);
        check("t1_valid_drop", st_valid, 34'd0);
        check("t1_q_empty", 34'(exp_q.size()), 34'd0);
        @(posedge clk); #1;

        // Error terminations; word_idx is 1 after the four words above.
        wb_single(1'b1, 32'h0, 32'hAA, 4'h3, a, r, q);
        check("err_sel", {a, r}, 34'b01);
        wb_single(1'b0, 32'h0, 32'h0, 4'hF, a, r, q);
        check("err_rd_data", {a, r}, 34'b01);
        wb_single(1'b0, 32'h4, 32'h0, 4'hF, a, r, q);
        check("err_status", q, 34'h0001_0000);
        wb_single(1'b1, 32'h4, 32'h1, 4'hF, a, r, q);
        check("flush_ack", {a, r}, 34'b10);

        // Fill a depth-4 FIFO with the sink stalled, then free one slot.
        st_ready = 1'b0;
        push_word("t2_push0", 32'h51, 1'b1, 1'b0);
        push_word("t2_push1", 32'h52, 1'b0, 1'b0);
        push_word("t2_push2", 32'h53, 1'b0, 1'b1);
        push_word("t2_push3", 32'h54, 1'b1, 1'b0);
        exp_q.push_back({2'b00, 32'h55});
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_ms = 32'h55; sel = 4'hF;
        @(negedge clk);
        check("t2_stall_full", stall, 34'd1);
        @(posedge clk); #1;
        st_ready = 1'b1;
        @(negedge clk);
        check("t2_stall_popcyc", stall, 34'd1);
        check("t2_no_ack", ack, 34'd0);
        @(posedge clk); #1;
        st_ready = 1'b0;
        @(negedge clk);
        check("t2_stall_drop", stall, 34'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("t2_ack5", ack, 34'd1);
        @(posedge clk); #1;
        drain("t2_drain");

        // word_idx is now 2: buffer three words and inspect STATUS.
        st_ready = 1'b0;
        push_word("t4_push0", 32'h61, 1'b0, 1'b1);
        push_word("t4_push1", 32'h62, 1'b1, 1'b0);
        push_word("t4_push2", 32'h63, 1'b0, 1'b0);
        wb_single(1'b0, 32'h4, 32'h0, 4'hF, a, r, q);
        check("t4_status", {a, r, q}, {2'b10, 32'h0002_0003});
        wb_single(1'b1, 32'h4, 32'h0, 4'hF, a, r, q);
        check("t4_noop_ack", {a, r}, 34'b10);
        wb_single(1'b0, 32'h4, 32'h0, 4'hF, a, r, q);
        check("t4_status_noop", q, 34'h0002_0003);
        wb_single(1'b1, 32'h4, 32'h1, 4'hF, a, r, q);
        exp_q.delete();
        check("t4_flush_ack", {a, r}, 34'b10);
        wb_single(1'b0, 32'h4, 32'h0, 4'hF, a, r, q);
        check("t4_status_flushed", q, 34'h0);
        check("t4_valid_flushed", st_valid, 34'd0);
        push_word("t4_push_sop", 32'h71, 1'b1, 1'b0);
        drain("t4_drain");

        // Seven words under random backpressure, starting from a fresh frame.
        wb_single(1'b1, 32'h4, 32'h1, 4'hF, a, r, q);
        check("t5_flush_ack", {a, r}, 34'b10);
        rand_ready_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            push_word("t5_push", 32'hC0DE_0000 + 32'(k), (k % 3) == 0, (k % 3) == 2);
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #1;
        drain("t5_drain");

        // Reset mid-frame with two words buffered and a STATUS ack in flight.
        st_ready = 1'b0;
        push_word("t6_push0", 32'h91, 1'b0, 1'b0);
        push_word("t6_push1", 32'h92, 1'b0, 1'b1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        check("t6_pre_ack", {ack, dat_sm}, {1'b0, 1'b1, 32'h0001_0002});
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_outs", {ack, err, stall, st_valid, st_sop, st_eop}, 34'b000010);
        check("t6_rst_dat_sm", dat_sm, 34'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_word("t6_push_sop", 32'h81, 1'b1, 1'b0);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
